aes_core_arbiter: RTL and testbench
===================================

Name: aes_core_arbiter

Overview:
Round-robin scheduler that shares a single AES-128 encryption core between NUM_REQ requesters. It accepts one plaintext/key job at a time over a valid/ready handshake and issues a one-cycle start to the core. It waits for the core's done pulse, then returns the ciphertext tagged with the requester ID over a valid/ready response channel. The block sits between the bus-side crypto clients and the AES core, and is the only driver of the core's start/state/key inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).
TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with AES_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  reset, synchronous, active-high.
req_valid  in  NUM_REQ  per-requester job valid.
req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
req_pt  in  NUM_REQ*128  plaintexts; requester i occupies bits [128*i+127:128*i].
req_key  in  NUM_REQ*128  keys; same packing as req_pt.
core_start  out  1  one-cycle start pulse to the AES core.
core_state  out  128  plaintext to the core; held stable from ISSUE until core_done.
core_key  out  128  key to the core; held stable from ISSUE until core_done.
core_done  in  1  one-cycle completion pulse from the core.
core_out  in  128  ciphertext; valid in the cycle core_done is high.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_id  out  ID_W  ID of the requester that owns the response.
rsp_ct  out  128  ciphertext.
rsp_err  out  1  timeout flag (see Optional Feature).
busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset value IDLE.
- Reset values: all outputs 0; round-robin pointer ptr=0; job registers 0.
- IDLE
  - The winner is the first set bit of req_valid, searching circularly from ptr.
  - req_ready is combinational: one-hot on the winner, and only while in IDLE.
  - On the transfer cycle (req_valid[w] & req_ready[w]), latch pt, key and w into the job registers; next state ISSUE.
  - If no req_valid bit is set, stay in IDLE with all req_ready=0.
- ISSUE (exactly one cycle)
  - core_start=1; core_state/core_key driven from the job registers.
  - Next state WAIT.
  - A core_done seen in this cycle is ignored.
- WAIT
  - core_start=0; core_state/core_key stay held.
  - On core_done=1: latch core_out into rsp_ct; next state RESP.
- RESP
  - rsp_valid=1. rsp_id, rsp_ct and rsp_err stay stable until the handshake.
  - On rsp_ready=1: ptr <= (w+1) mod NUM_REQ, rsp_valid drops the next cycle, next state IDLE.
  - Back-to-back operation: a new grant is possible in the first IDLE cycle after the handshake.
- Latency: request transfer at cycle T gives core_start at T+1 and rsp_valid at D+1, where D is the core_done cycle.
- Fairness: the pointer advances only after a completed response, so no requester waits more than NUM_REQ-1 jobs.
- Requesters dropping req_valid while not granted is legal and has no effect.
- Reset asserted mid-operation (any state) abandons the job. No response is produced, core_start is 0 from the next cycle, and ptr returns to 0. A core_done arriving after reset, while in IDLE, is ignored.
- core_done in IDLE or RESP is ignored; no error is flagged.

Optional Feature:
Macro AES_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no core_done, go to RESP with rsp_err=1 and rsp_ct=0.
  - core_done in the same cycle as the limit wins: the response is normal with rsp_err=0.
- Not defined: there is no counter, rsp_err is tied to 0, and WAIT lasts indefinitely.

Test Plan:
- Single job: NUM_REQ=4. Requester 2 sends pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c. The model core pulses done 10 cycles after start with ct=3925841d02dc09fbdc118597196a0b32. Required: core_start exactly 1 cycle after transfer; rsp_valid 1 cycle after done; rsp_id=2; rsp_ct matches.
- Contention: all 4 req_valid held high from reset. Required: grant order 0,1,2,3,0; exactly one req_ready bit at a time; never asserted outside IDLE.
- Backpressure: rsp_ready held low for 7 cycles in RESP. Required: rsp_valid/id/ct stable throughout; req_ready stays 0; the next grant comes only after the handshake.
- Pointer wrap: after requester 3 is served, requesters 1 and 0 are valid. Required: requester 0 is granted next.
- Reset mid-WAIT: assert rst for 1 cycle 3 cycles after core_start, then pulse core_done. Required: no rsp_valid; busy=0; the next job from requester 1 is granted first with ptr=0 order.
- With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: the core never pulses done. Required: rsp_valid on WAIT cycle 16 with rsp_err=1 and rsp_ct=0. Repeat with done on exactly cycle 16: required rsp_err=0.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between NUM_REQ requesters.
// Optional WAIT watchdog enabled with `define AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_pt,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   core_start,
    output logic [127:0]           core_state,
    output logic [127:0]           core_key,
    input  logic                   core_done,
    input  logic [127:0]           core_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_ct,
    output logic                   rsp_err,
    output logic                   busy
);

    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [127:0]    pt_q, pt_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    ct_q, ct_d;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;

    // Walk downwards so the closest set bit at or after ptr is the one that sticks.
    always_comb begin
        grant   = '0;
        win_id  = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        if (win_vld) grant[win_id] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        pt_d      = pt_q;
        key_d     = key_q;
        ct_d      = ct_q;
        req_ready = '0;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rst) req_ready = grant;
                if (win_vld) begin
                    pt_d    = req_pt[int'(win_id)*128 +: 128];
                    key_d   = req_key[int'(win_id)*128 +: 128];
                    id_d    = win_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (core_done) begin
                    ct_d    = core_out;
                    state_d = RESP;
`ifdef AES_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            ct_q    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign core_start = (state_q == ISSUE);
    assign core_state = pt_q;
    assign core_key   = key_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_ct     = ct_q;
    assign busy       = (state_q != IDLE);
`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: transaction-level model checked every cycle,
// a behavioural AES core stand-in, and directed scenarios with literal expectations.
module tb_aes_core_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*128-1:0] req_pt, req_key;
    logic           core_start, core_done, rsp_valid, rsp_ready, rsp_err, busy;
    logic [127:0]   core_state, core_key, core_out, rsp_ct;
    logic [1:0]     rsp_id;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_pt(req_pt), .req_key(req_key), .core_start(core_start),
        .core_state(core_state), .core_key(core_key), .core_done(core_done),
        .core_out(core_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_ct(rsp_ct), .rsp_err(rsp_err), .busy(busy)
    );

    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    function automatic logic [127:0] aes_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a;
    endfunction
    function automatic logic [127:0] mkpt(input int i);
        return {32'(i * 7 + 1), 96'h0123456789abcdef01234567};
    endfunction
    function automatic logic [127:0] mkkey(input int i);
        return {96'hfedcba9876543210fedcba98, 32'(i + 9)};
    endfunction
    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // model state: one job in flight, tracked by the cycle numbers of its events
    int ncyc = 0;
    bit m_act = 0, m_done = 0, m_err = 0;
    int m_ptr = 0, m_id = 0, m_xcyc = 0;
    logic [127:0] m_pt, m_key, m_ct;
    int glog[$];
    int grant_total = 0, rsp_total = 0, done_total = 0;
    int last_xfer = 0, last_start = 0, last_done = 0, last_rsp = 0;
    logic [127:0] last_ct;
    int last_id = 0;
    bit last_err = 0, prev_rsp = 0;
    logic [N-1:0] g_mask, oneshot;
    int stop_at = 1000;
    bit st_seen = 0;
    int core_lat = 10, cd_cnt = 0;
    logic [127:0] pend_ct = '0;

    task automatic model_step();
        logic [N-1:0] er;
        int ew;
        g_mask  = '0;
        st_seen = core_start;
        if (rst) begin
            m_act = 0; m_done = 0; m_ptr = 0; prev_rsp = 0;
            return;
        end
        ew = winner(req_valid, m_ptr);
        er = '0;
        if (!m_act && ew >= 0) er[ew] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("onehot", 128'($countones(req_ready) <= 1), 128'(1));
        chk("busy", 128'(busy), 128'(m_act));
        chk("core_start", 128'(core_start), 128'(m_act && ncyc == m_xcyc + 1));
        chk("rsp_valid", 128'(rsp_valid), 128'(m_act && m_done));
        if (m_act) begin
            chk("core_state", core_state, m_pt);
            chk("core_key", core_key, m_key);
        end
        if (m_act && m_done) begin
            chk("rsp_id", 128'(rsp_id), 128'(m_id));
            chk("rsp_ct", rsp_ct, m_ct);
            chk("rsp_err", 128'(rsp_err), 128'(m_err));
        end
        if (core_start) last_start = ncyc;
        if (rsp_valid && !prev_rsp) begin
            last_rsp = ncyc; last_id = int'(rsp_id); last_ct = rsp_ct; last_err = rsp_err;
        end
        prev_rsp = rsp_valid;
        if (!m_act) begin
            g_mask = req_valid & req_ready;
            if (ew >= 0) begin
                m_act = 1; m_done = 0; m_xcyc = ncyc; m_id = ew;
                m_pt = req_pt[ew*128 +: 128]; m_key = req_key[ew*128 +: 128];
                glog.push_back(ew); grant_total++; last_xfer = ncyc;
            end
        end else if (!m_done) begin
            if (core_done && ncyc > m_xcyc + 1) begin
                m_done = 1; m_err = 0; m_ct = aes_fn(m_pt, m_key); last_done = ncyc;
            end
`ifdef AES_ARB_TIMEOUT_EN
            else if (ncyc == m_xcyc + 1 + TO) begin
                m_done = 1; m_err = 1; m_ct = '0;
            end
`endif
        end else if (rsp_ready) begin
            m_act = 0; m_ptr = (m_id + 1) % N; rsp_total++;
        end
    endtask

    // one clock: check/model on the falling edge, drive inputs just after the rising edge
    task automatic tick();
        @(negedge clk);
        ncyc++;
        model_step();
        @(posedge clk);
        #1;
        if (st_seen && core_lat > 0) begin
            cd_cnt  = core_lat;
            pend_ct = aes_fn(core_state, core_key);
        end
        core_done = 1'b0;
        core_out  = ~pend_ct;
        if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) begin core_done = 1'b1; core_out = pend_ct; done_total++; end
        end
        req_valid = req_valid & ~(g_mask & oneshot);
        if (grant_total >= stop_at) req_valid = '0;
    endtask

    task automatic wait_rsp(input int n, input string name);
        int b = 0;
        while (rsp_total < n && b < 400) begin tick(); b++; end
        chk(name, 128'(rsp_total >= n), 128'(1));
    endtask

    int base, r0;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        req_valid = '0; rsp_ready = 1'b1; core_done = 1'b0; core_out = '0;
        oneshot = '1;
        for (int i = 0; i < N; i++) begin
            req_pt[i*128 +: 128]  = mkpt(i);
            req_key[i*128 +: 128] = mkkey(i);
        end
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_start", 128'(core_start), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_ready", 128'(req_ready), 128'(0));
        chk("rst_ct", rsp_ct, 128'(0));
        chk("rst_state", core_state, 128'(0));

        // single job, known-answer vector
        req_pt[2*128 +: 128] = FIPS_PT; req_key[2*128 +: 128] = FIPS_KEY;
        req_valid[2] = 1'b1;
        wait_rsp(1, "single_done");
        chk("single_start_lat", 128'(last_start - last_xfer), 128'(1));
        chk("single_done_lat", 128'(last_done - last_start), 128'(10));
        chk("single_rsp_lat", 128'(last_rsp - last_done), 128'(1));
        chk("single_id", 128'(last_id), 128'(2));
        chk("single_ct", last_ct, FIPS_CT);
        req_pt[2*128 +: 128] = mkpt(2); req_key[2*128 +: 128] = mkkey(2);

        // contention from reset
        req_valid = '1; oneshot = '0; core_lat = 3;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        base = glog.size(); stop_at = grant_total + 5;
        wait_rsp(rsp_total + 5, "contend_done");
        for (int k = 0; k < 5; k++)
            chk("contend_order", 128'(glog[base + k]), 128'(exp_order[k]));
        oneshot = '1; stop_at = 1000;

        // backpressure: requester 1 then 3
        rsp_ready = 1'b0; core_lat = 2; req_valid[1] = 1'b1; r0 = rsp_total;
        for (int b = 0; b < 50 && !rsp_valid; b++) tick();
        req_valid[3] = 1'b1;
        repeat (7) begin
            tick();
            chk("bp_valid", 128'(rsp_valid), 128'(1));
            chk("bp_id", 128'(rsp_id), 128'(1));
            chk("bp_ct", rsp_ct, aes_fn(mkpt(1), mkkey(1)));
            chk("bp_ready", 128'(req_ready), 128'(0));
        end
        chk("bp_no_grant", 128'(glog.size()), 128'(grant_total));
        chk("bp_last_grant", 128'(glog[$]), 128'(1));
        rsp_ready = 1'b1;
        wait_rsp(r0 + 2, "bp_done");
        chk("bp_next_grant", 128'(glog[$]), 128'(3));

        // pointer wrap after requester 3
        req_valid[1] = 1'b1; req_valid[0] = 1'b1;
        wait_rsp(r0 + 4, "wrap_done");
        chk("wrap_first", 128'(glog[$-1]), 128'(0));
        chk("wrap_second", 128'(glog[$]), 128'(1));

        // reset three cycles into the job, late done must be ignored
        core_lat = 10; req_valid[2] = 1'b1;
        for (int b = 0; b < 50 && !core_start; b++) tick();
        repeat (3) tick();
        rst = 1'b1; r0 = rsp_total; base = done_total;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("rst_late_done_seen", 128'(done_total > base), 128'(1));
        chk("rst_no_rsp", 128'(rsp_total), 128'(r0));
        chk("rst_idle", 128'(busy), 128'(0));
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        wait_rsp(r0 + 2, "rst_after_done");
        chk("rst_ptr_first", 128'(glog[$-1]), 128'(1));
        chk("rst_ptr_second", 128'(glog[$]), 128'(3));

`ifdef AES_ARB_TIMEOUT_EN
        core_lat = 0; req_valid[0] = 1'b1; r0 = rsp_total;
        wait_rsp(r0 + 1, "to_done");
        chk("to_err", 128'(last_err), 128'(1));
        chk("to_ct", last_ct, 128'(0));
        chk("to_lat", 128'(last_rsp - last_start), 128'(17));
        core_lat = 16; req_valid[0] = 1'b1;
        wait_rsp(r0 + 2, "to_edge_done");
        chk("to_edge_err", 128'(last_err), 128'(0));
        chk("to_edge_ct", last_ct, aes_fn(mkpt(0), mkkey(0)));
        chk("to_edge_lat", 128'(last_rsp - last_start), 128'(17));
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
